// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both the operand and result sides.

module ripple_carry_adder_subtractor #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CTRL,
    output logic [N-1:0] S,
    output logic         COUT
);
    logic [N:0]   carry;
    logic [N-1:0] b_eff;

    assign carry[0] = CTRL;

    // CTRL=1 turns the adder into A + ~B + 1; COUT=1 then means no borrow
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fa
            assign b_eff[gi]   = B[gi] ^ CTRL;
            assign S[gi]       = A[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi+1] = (A[gi] & b_eff[gi]) | (carry[gi] & (A[gi] ^ b_eff[gi]));
        end
    endgenerate

    assign COUT = carry[N];
endmodule

module seq_restoring_divider #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] Q,
    output logic [SIZE-1:0] R,
    output logic            DBZ
);
    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [SIZE:0]   rem_reg, rem_next;
    logic [SIZE-1:0] q_reg, q_next;
    logic [SIZE-1:0] b_reg, b_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [SIZE-1:0] qo_reg, qo_next;
    logic [SIZE-1:0] ro_reg, ro_next;
    logic            dbz_reg, dbz_next;

    logic [SIZE:0]   rem_s;
    logic [SIZE:0]   diff;
    logic            no_borrow;

    // rem is always < B, so its top bit is zero and drops out of the shift
    assign rem_s = (SIZE+1)'({rem_reg, q_reg[SIZE-1]});

    ripple_carry_adder_subtractor #(.N(SIZE + 1)) u_trial_sub (
        .A    (rem_s),
        .B    ({1'b0, b_reg}),
        .CTRL (1'b1),
        .S    (diff),
        .COUT (no_borrow)
    );

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign Q         = qo_reg;
    assign R         = ro_reg;
    assign DBZ       = dbz_reg;

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        q_next     = q_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        qo_next    = qo_reg;
        ro_next    = ro_reg;
        dbz_next   = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (B == '0) begin
                        qo_next    = '1;
                        ro_next    = A;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        b_next     = B;
                        rem_next   = '0;
                        q_next     = A;
                        cnt_next   = '0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                rem_next = no_borrow ? diff : rem_s;
                q_next   = {q_reg[SIZE-2:0], no_borrow};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    qo_next    = q_next;
                    ro_next    = rem_next[SIZE-1:0];
                    dbz_next   = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            q_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            qo_reg    <= '0;
            ro_reg    <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            q_reg     <= q_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            qo_reg    <= qo_next;
            ro_reg    <= ro_next;
            dbz_reg   <= dbz_next;
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep checks of seq_restoring_divider at SIZE=4 and SIZE=8,
// sharing one stimulus path selected by sel.

module tb_seq_restoring_divider;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       iv = 1'b0;
    logic       ordy = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       ir4, ov4, dbz4, ir8, ov8, dbz8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;
    logic       o_ir, o_ov, o_dbz;
    logic [7:0] o_q, o_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.SIZE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(ir4),
        .A(a[3:0]), .B(b[3:0]), .out_valid(ov4), .out_ready(ordy & ~sel),
        .Q(q4), .R(r4), .DBZ(dbz4)
    );

    seq_restoring_divider #(.SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(ir8),
        .A(a), .B(b), .out_valid(ov8), .out_ready(ordy & sel),
        .Q(q8), .R(r8), .DBZ(dbz8)
    );

    assign o_ir  = sel ? ir8  : ir4;
    assign o_ov  = sel ? ov8  : ov4;
    assign o_dbz = sel ? dbz8 : dbz4;
    assign o_q   = sel ? q8   : {4'h0, q4};
    assign o_r   = sel ? r8   : {4'h0, r4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for result, hold, handshake.
    task automatic run(input logic s, input logic [7:0] ta, input logic [7:0] tb_v,
                       input int hold, input bit garbage);
        logic [7:0] eq, er;
        logic       ed;
        int         lat, n;
        if (tb_v == 8'h00) begin
            eq = s ? 8'hFF : 8'h0F; er = ta; ed = 1'b1; lat = 0;
        end else begin
            eq = ta / tb_v; er = ta % tb_v; ed = 1'b0; lat = s ? 8 : 4;
        end
        @(negedge clk);
        sel = s;
        ordy = 1'b0;
        #1 chk("in_ready_idle", o_ir, 1);
        iv = 1'b1; a = ta; b = tb_v;
        @(posedge clk); #1;
        if (garbage) begin
            a = ~ta; b = tb_v + 8'd1;
        end else begin
            iv = 1'b0;
        end
        n = 0;
        while (!o_ov && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, lat);
        chk("q", o_q, eq);
        chk("r", o_r, er);
        chk("dbz", o_dbz, ed);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", o_ov, 1);
            chk("hold_q", o_q, eq);
            chk("hold_r", o_r, er);
        end
        @(negedge clk);
        iv = 1'b0; ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("post_hs_valid", o_ov, 0);
        chk("post_hs_ready", o_ir, 1);
        chk("post_hs_q", o_q, eq);
        $display("[TB] SIZE=%0d A=%0d B=%0d -> Q=%0d R=%0d DBZ=%0b lat=%0d hold=%0d",
                 s ? 8 : 4, ta, tb_v, o_q, o_r, o_dbz, n, hold);
    endtask

    initial begin
        bit spurious;
        // Reset state
        #1;
        chk("rst_ready4", ir4, 1);
        chk("rst_valid4", ov4, 0);
        chk("rst_q4", q4, 0);
        chk("rst_valid8", ov8, 0);
        @(negedge clk); rst = 1'b0;

        // Directed vectors
        run(1'b0, 8'd11, 8'd3, 0, 1'b0);
        run(1'b0, 8'd15, 8'd1, 0, 1'b0);
        run(1'b0, 8'd5,  8'd7, 0, 1'b0);
        run(1'b0, 8'd0,  8'd9, 0, 1'b0);
        run(1'b0, 8'd9,  8'd0, 0, 1'b0);

        // Backpressure with in_valid asserted throughout CALC/DONE
        run(1'b0, 8'd14, 8'd4, 6, 1'b1);
        run(1'b0, 8'd7,  8'd0, 6, 1'b1);

        // Asynchronous reset mid-cycle clears the held result at once
        run(1'b0, 8'd11, 8'd3, 0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_q", o_q, 0);
        chk("async_rst_r", o_r, 0);
        chk("async_rst_valid", o_ov, 0);
        chk("async_rst_ready", o_ir, 1);
        @(negedge clk); rst = 1'b0;

        // Reset during CALC aborts the operation
        @(negedge clk);
        sel = 1'b0; iv = 1'b1; a = 8'd13; b = 8'd2;
        @(posedge clk); #1 iv = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("calc_rst_ready", o_ir, 1);
        chk("calc_rst_valid", o_ov, 0);
        @(negedge clk); rst = 1'b0;
        spurious = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_ov) spurious = 1'b1;
        end
        chk("no_spurious_result", spurious, 0);
        run(1'b0, 8'd13, 8'd2, 0, 1'b0);

        // Exhaustive SIZE=4 sweep with random backpressure
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run(1'b0, 8'(ia), 8'(ib), int'($urandom_range(0, 2)), 1'(($urandom & 3) == 0));
            end
        end

        // SIZE=8 directed corners then random pairs
        run(1'b1, 8'd255, 8'd1,   0, 1'b0);
        run(1'b1, 8'd200, 8'd0,   2, 1'b0);
        run(1'b1, 8'd254, 8'd255, 1, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            run(1'b1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
